// File: rtl/rv_float_reg_file_pkg.sv
// rv_float_reg_file_pkg: shared defaults and the write-port priority select for the FP register file.
package rv_float_reg_file_pkg;
  localparam int NUM_REGS_DEF = 32;
  localparam int FLEN_DEF = 64;
  localparam int NUM_RD_DEF = 3;
  localparam int NUM_WR_DEF = 2;
  localparam int MAX_WR = 8;
  // One-hot of the highest set bit: the highest-indexed matching write port wins.
  function automatic logic [MAX_WR-1:0] hi_onehot(input logic [MAX_WR-1:0] hit);
    hi_onehot = '0;
    for (int k = 0; k < MAX_WR; k++)
      if (hit[k]) begin
        hi_onehot = '0;
        hi_onehot[k] = 1'b1;
      end
  endfunction
endpackage

// File: rtl/rv_float_reg_file_if.sv
// rv_float_reg_file_if: issue/writeback/read bus of the scoreboarded FP register file.
interface rv_float_reg_file_if #(
  parameter int NUM_REGS = 32,
  parameter int FLEN = 64,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2
);
  localparam int AW = $clog2(NUM_REGS);
  logic [NUM_WR-1:0] wr_en_i;
  logic [NUM_WR-1:0][AW-1:0] wr_addr_i;
  logic [NUM_WR-1:0][FLEN-1:0] wr_data_i;
  logic [NUM_RD-1:0][AW-1:0] rs_addr_i;
  logic [NUM_RD-1:0][FLEN-1:0] rs_data_o;
  logic [NUM_RD-1:0] rs_busy_o;
  logic alloc_en_i;
  logic [AW-1:0] alloc_addr_i;
  logic alloc_ready_o;
  logic [NUM_REGS-1:0] busy_o;
  logic err_o;
  modport slave (
    input wr_en_i, wr_addr_i, wr_data_i, rs_addr_i, alloc_en_i, alloc_addr_i,
    output rs_data_o, rs_busy_o, alloc_ready_o, busy_o, err_o
  );
  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rs_addr_i, alloc_en_i, alloc_addr_i,
    input rs_data_o, rs_busy_o, alloc_ready_o, busy_o, err_o
  );
endinterface

// File: rtl/rv_float_reg_file_scoreboard.sv
// rv_float_reg_file_scoreboard: per-register busy bits, allocation handshake and sticky writeback error.
module rv_float_reg_file_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_WR = 2,
  parameter int AW = $clog2(NUM_REGS)
) (
  input logic clk_i,
  input logic arst_ni,
  input logic [NUM_WR-1:0] wr_en_i,
  input logic [NUM_WR-1:0][AW-1:0] wr_addr_i,
  input logic alloc_en_i,
  input logic [AW-1:0] alloc_addr_i,
  output logic alloc_ready_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic err_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic err_q, err_d;
  logic wr_alloc_hit;
  // Writebacks clear first, so a same-cycle allocation to that index leaves it busy.
  always_comb begin
    busy_d = busy_q;
    err_d = err_q;
    wr_alloc_hit = 1'b0;
    for (int k = 0; k < NUM_WR; k++)
      if (wr_en_i[k]) begin
        busy_d[wr_addr_i[k]] = 1'b0;
        err_d = err_d | ~busy_q[wr_addr_i[k]];
        wr_alloc_hit = wr_alloc_hit | (wr_addr_i[k] == alloc_addr_i);
      end
    alloc_ready_o = ~busy_q[alloc_addr_i] | wr_alloc_hit;
    if (alloc_en_i && alloc_ready_o) busy_d[alloc_addr_i] = 1'b1;
  end
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) begin
      busy_q <= '0;
      err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q <= err_d;
    end
  assign busy_o = busy_q;
  assign err_o = err_q;
endmodule

// File: rtl/rv_float_reg_file_sb.sv
// rv_float_reg_file_sb: N-write/M-read scoreboarded FP register file.
// Define FP_REG_FILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module rv_float_reg_file_sb
  import rv_float_reg_file_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int FLEN = FLEN_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int NUM_WR = NUM_WR_DEF
) (
  input logic clk_i,
  input logic arst_ni,
  rv_float_reg_file_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  logic [NUM_REGS-1:0][FLEN-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0][MAX_WR-1:0] wr_hit;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_RD-1:0][FLEN-1:0] rs_data;
  logic [NUM_RD-1:0] rs_busy;
  function automatic logic [FLEN-1:0] wr_mux(input logic [MAX_WR-1:0] oh,
                                             input logic [NUM_WR-1:0][FLEN-1:0] data);
    wr_mux = '0;
    for (int k = 0; k < NUM_WR; k++) wr_mux = wr_mux | ({FLEN{oh[k]}} & data[k]);
  endfunction
  always_comb begin
    wr_hit = '0;
    regs_d = regs_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int k = 0; k < NUM_WR; k++)
        wr_hit[r][k] = bus.wr_en_i[k] && (bus.wr_addr_i[k] == AW'(r));
      regs_d[r] = |wr_hit[r] ? wr_mux(hi_onehot(wr_hit[r]), bus.wr_data_i) : regs_q[r];
    end
  end
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) regs_q <= '0;
    else regs_q <= regs_d;
`ifdef FP_REG_FILE_BYPASS_EN
  logic [NUM_RD-1:0][MAX_WR-1:0] rd_hit;
  always_comb begin
    rd_hit = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      for (int k = 0; k < NUM_WR; k++)
        rd_hit[j][k] = bus.wr_en_i[k] && (bus.wr_addr_i[k] == bus.rs_addr_i[j]);
      rs_data[j] = |rd_hit[j] ? wr_mux(hi_onehot(rd_hit[j]), bus.wr_data_i)
                              : regs_q[bus.rs_addr_i[j]];
      rs_busy[j] = ~|rd_hit[j] & busy[bus.rs_addr_i[j]];
    end
  end
`else
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      rs_data[j] = regs_q[bus.rs_addr_i[j]];
      rs_busy[j] = busy[bus.rs_addr_i[j]];
    end
  end
`endif
  rv_float_reg_file_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .NUM_WR(NUM_WR),
    .AW(AW)
  ) u_sb (
    .clk_i(clk_i),
    .arst_ni(arst_ni),
    .wr_en_i(bus.wr_en_i),
    .wr_addr_i(bus.wr_addr_i),
    .alloc_en_i(bus.alloc_en_i),
    .alloc_addr_i(bus.alloc_addr_i),
    .alloc_ready_o(bus.alloc_ready_o),
    .busy_o(busy),
    .err_o(bus.err_o)
  );
  assign bus.busy_o = busy;
  assign bus.rs_data_o = rs_data;
  assign bus.rs_busy_o = rs_busy;
endmodule

// File: tb/tb_rv_float_reg_file_sb.sv
// tb_rv_float_reg_file_sb: directed checks of reset, scoreboard handshake, write priority, err and bypass.
module tb_rv_float_reg_file_sb;
  logic clk_i = 1'b0;
  logic arst_ni = 1'b0;
  int checks = 0;
  int errors = 0;
  rv_float_reg_file_if #(.NUM_REGS(32), .FLEN(64), .NUM_RD(3), .NUM_WR(2)) bus ();
  rv_float_reg_file_sb #(.NUM_REGS(32), .FLEN(64), .NUM_RD(3), .NUM_WR(2)) dut (
    .clk_i(clk_i),
    .arst_ni(arst_ni),
    .bus(bus)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic idle();
    bus.wr_en_i = '0;
    bus.alloc_en_i = 1'b0;
  endtask
  initial begin
    idle();
    bus.wr_addr_i = '0;
    bus.wr_data_i = '0;
    bus.rs_addr_i = '0;
    bus.alloc_addr_i = '0;
    #2;
    for (int r = 0; r < 32; r++) begin
      bus.rs_addr_i[0] = 5'(r);
      #1;
      chk($sformatf("reset_data_f%0d", r), bus.rs_data_o[0], 64'h0);
      chk($sformatf("reset_rsbusy_f%0d", r), {63'h0, bus.rs_busy_o[0]}, 64'h0);
    end
    chk("reset_busy", {32'h0, bus.busy_o}, 64'h0);
    chk("reset_ready", {63'h0, bus.alloc_ready_o}, 64'h1);
    chk("reset_err", {63'h0, bus.err_o}, 64'h0);
    @(negedge clk_i);
    arst_ni = 1'b1;
    tick();
    // allocate f5, then re-allocate while busy, then write it back
    bus.alloc_en_i = 1'b1;
    bus.alloc_addr_i = 5'd5;
    #1 chk("alloc5_ready", {63'h0, bus.alloc_ready_o}, 64'h1);
    tick();
    idle();
    bus.rs_addr_i[0] = 5'd5;
    #1 chk("alloc5_rsbusy", {63'h0, bus.rs_busy_o[0]}, 64'h1);
    chk("alloc5_busyvec", {32'h0, bus.busy_o}, 64'h20);
    bus.alloc_en_i = 1'b1;
    #1 chk("realloc5_ready", {63'h0, bus.alloc_ready_o}, 64'h0);
    tick();
    idle();
    chk("realloc5_busyvec", {32'h0, bus.busy_o}, 64'h20);
    bus.wr_en_i[0] = 1'b1;
    bus.wr_addr_i[0] = 5'd5;
    bus.wr_data_i[0] = 64'h3FF0_0000_0000_0000;
    #1 chk("wb5_ready_inflight", {63'h0, bus.alloc_ready_o}, 64'h1);
    tick();
    idle();
    #1 chk("wb5_rsbusy", {63'h0, bus.rs_busy_o[0]}, 64'h0);
    chk("wb5_data", bus.rs_data_o[0], 64'h3FF0_0000_0000_0000);
    chk("wb5_err", {63'h0, bus.err_o}, 64'h0);
    // both ports write f7: port 1 wins
    bus.alloc_en_i = 1'b1;
    bus.alloc_addr_i = 5'd7;
    tick();
    idle();
    bus.wr_en_i = 2'b11;
    bus.wr_addr_i[0] = 5'd7;
    bus.wr_addr_i[1] = 5'd7;
    bus.wr_data_i[0] = 64'h1111_1111_1111_1111;
    bus.wr_data_i[1] = 64'h2222_2222_2222_2222;
    tick();
    idle();
    bus.rs_addr_i[1] = 5'd7;
    #1 chk("dual7_data", bus.rs_data_o[1], 64'h2222_2222_2222_2222);
    chk("dual7_busyvec", {32'h0, bus.busy_o}, 64'h0);
    chk("dual7_err", {63'h0, bus.err_o}, 64'h0);
    // same-cycle writeback and allocation of busy f9
    bus.alloc_en_i = 1'b1;
    bus.alloc_addr_i = 5'd9;
    tick();
    idle();
    bus.wr_en_i[0] = 1'b1;
    bus.wr_addr_i[0] = 5'd9;
    bus.wr_data_i[0] = 64'hAAAA_5555_AAAA_5555;
    bus.alloc_en_i = 1'b1;
    bus.alloc_addr_i = 5'd9;
    #1 chk("wballoc9_ready", {63'h0, bus.alloc_ready_o}, 64'h1);
    tick();
    idle();
    bus.rs_addr_i[2] = 5'd9;
    #1 chk("wballoc9_data", bus.rs_data_o[2], 64'hAAAA_5555_AAAA_5555);
    chk("wballoc9_busyvec", {32'h0, bus.busy_o}, 64'h200);
    chk("wballoc9_rsbusy", {63'h0, bus.rs_busy_o[2]}, 64'h1);
    bus.wr_en_i[1] = 1'b1;
    bus.wr_addr_i[1] = 5'd9;
    bus.wr_data_i[1] = 64'h0BAD_F00D_0000_0009;
    tick();
    idle();
    #1 chk("wb9_data", bus.rs_data_o[2], 64'h0BAD_F00D_0000_0009);
    chk("wb9_busyvec", {32'h0, bus.busy_o}, 64'h0);
    // read f4 while it is being written back
    bus.alloc_en_i = 1'b1;
    bus.alloc_addr_i = 5'd4;
    tick();
    idle();
    bus.rs_addr_i[1] = 5'd4;
    bus.rs_addr_i[2] = 5'd5;
    bus.wr_en_i[0] = 1'b1;
    bus.wr_addr_i[0] = 5'd4;
    bus.wr_data_i[0] = 64'h0000_0000_DEAD_BEEF;
    #1;
`ifdef FP_REG_FILE_BYPASS_EN
    chk("byp4_data", bus.rs_data_o[1], 64'h0000_0000_DEAD_BEEF);
    chk("byp4_rsbusy", {63'h0, bus.rs_busy_o[1]}, 64'h0);
`else
    chk("byp4_data", bus.rs_data_o[1], 64'h0);
    chk("byp4_rsbusy", {63'h0, bus.rs_busy_o[1]}, 64'h1);
`endif
    chk("byp4_other_port", bus.rs_data_o[2], 64'h3FF0_0000_0000_0000);
    tick();
    idle();
    #1 chk("wb4_data", bus.rs_data_o[1], 64'h0000_0000_DEAD_BEEF);
    chk("wb4_rsbusy", {63'h0, bus.rs_busy_o[1]}, 64'h0);
    chk("wb4_err", {63'h0, bus.err_o}, 64'h0);
    // writeback to unallocated f3 sets sticky err
    bus.wr_en_i[1] = 1'b1;
    bus.wr_addr_i[1] = 5'd3;
    bus.wr_data_i[1] = 64'h4009_21FB_5444_2D18;
    #1 chk("err3_before_edge", {63'h0, bus.err_o}, 64'h0);
    tick();
    idle();
    bus.rs_addr_i[0] = 5'd3;
    #1 chk("err3_data", bus.rs_data_o[0], 64'h4009_21FB_5444_2D18);
    chk("err3_set", {63'h0, bus.err_o}, 64'h1);
    tick();
    tick();
    chk("err3_sticky", {63'h0, bus.err_o}, 64'h1);
    // async reset mid-operation drops an allocation in flight
    bus.alloc_en_i = 1'b1;
    bus.alloc_addr_i = 5'd10;
    tick();
    idle();
    chk("alloc10_busyvec", {32'h0, bus.busy_o}, 64'h400);
    @(negedge clk_i);
    arst_ni = 1'b0;
    #1 chk("arst_err", {63'h0, bus.err_o}, 64'h0);
    chk("arst_busyvec", {32'h0, bus.busy_o}, 64'h0);
    chk("arst_data3", bus.rs_data_o[0], 64'h0);
    chk("arst_data5", bus.rs_data_o[2], 64'h0);
    bus.alloc_addr_i = 5'd10;
    #1 chk("arst_ready", {63'h0, bus.alloc_ready_o}, 64'h1);
    @(negedge clk_i);
    arst_ni = 1'b1;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_float_reg_file_sb.md
# rv_float_reg_file_sb

Parametrised, scoreboarded floating-point register file for the FPU issue/writeback path, generalising the single-write, three-read FP register file to N write ports and M read ports. Each register carries a busy bit that is set when the issue stage allocates it as a destination and cleared on writeback, so operands are guarded against RAW hazards and destinations against WAW hazards. An optional write-to-read bypass lets a value written this cycle be consumed in the same cycle.

## Interface
- NUM_REGS, 32, number of architectural FP registers (power of two, ≥2); AW = $clog2(NUM_REGS)
- FLEN, 64, register width in bits
- NUM_RD, 3, read ports (rs1/rs2/rs3 for FMA)
- NUM_WR, 2, writeback ports
- clk_i  in  1  global clock
- arst_ni  in  1  asynchronous reset, active low
- wr_en_i  in  NUM_WR  per-port writeback valid
- wr_addr_i  in  NUM_WR×AW  writeback register index
- wr_data_i  in  NUM_WR×FLEN  writeback data
- rs_addr_i  in  NUM_RD×AW  source register index
- rs_data_o  out  NUM_RD×FLEN  source operand data
- rs_busy_o  out  NUM_RD  source has a pending write (operand not ready)
- alloc_en_i  in  1  issue stage requests destination allocation
- alloc_addr_i  in  AW  destination register to allocate
- alloc_ready_o  out  1  allocation accepted this cycle
- busy_o  out  NUM_REGS  full busy vector
- err_o  out  1  sticky: writeback to a non-busy register

## Operation
- Storage: NUM_REGS×FLEN flops; busy: NUM_REGS flops; err: 1 flop.
- Writeback: on each edge, for every k with wr_en_i[k], reg[wr_addr_i[k]] ← wr_data_i[k] and busy[wr_addr_i[k]] ← 0.
- Multiple write ports targeting the same index in one cycle: highest port index wins data; busy cleared once.
- Writeback to a register whose busy is 0: data still written; err ← 1 (sticky until reset).
- Allocation handshake: alloc fires when alloc_en_i && alloc_ready_o; busy[alloc_addr_i] ← 1.
- alloc_ready_o = !busy[alloc_addr_i] || (some wr_en_i[k] with wr_addr_i[k] == alloc_addr_i). Combinational; independent of alloc_en_i.
- Same-cycle writeback and allocation to the same index: data written, busy ends 1 (allocation wins).
- Reads: combinational, rs_data_o[j] = reg[rs_addr_i[j]]; rs_busy_o[j] = busy[rs_addr_i[j]] (modified by bypass, see Configuration).
- No register is hardwired; index 0 is an ordinary register.

## Timing
- Reset (async assert, sync-safe deassert by upstream): all registers 0, busy_o = 0, err_o = 0, hence rs_data_o = 0, rs_busy_o = 0, alloc_ready_o = 1.
- Reset mid-operation clears everything immediately; in-flight allocations are lost.
- Write latency: data visible on rs_data_o the cycle after the writing edge (same cycle with bypass).
- Allocation latency: busy_o and rs_busy_o reflect the allocation the cycle after the firing edge.
- err_o asserts the cycle after the offending edge.
- No internal stall state; throughput one allocation and NUM_WR writebacks per cycle.

## Configuration
- Macro FP_REG_FILE_BYPASS_EN.
- Defined: for each read port, if any wr_en_i[k] matches rs_addr_i[j], rs_data_o[j] = wr_data_i of the highest matching k and rs_busy_o[j] = 0.
- Undefined: reads return stored contents only; rs_busy_o[j] = busy[rs_addr_i[j]] even during a matching writeback. alloc_ready_o rule unchanged.

## Structure
- Package rv_float_reg_file_pkg: default NUM_REGS/FLEN constants and a priority-select function (highest matching write port index) shared by write and bypass logic.
- Sub-module rv_float_reg_file_scoreboard: busy vector, alloc_ready_o, err_o; data array and read/bypass muxes stay in the top.

## Test plan
- Reset, read all indices -> rs_data_o = 0, busy_o = 0, alloc_ready_o = 1, err_o = 0.
- Alloc f5, next cycle read f5 -> rs_busy_o = 1; alloc f5 again -> alloc_ready_o = 0; writeback 0x3FF0_0000_0000_0000 to f5 -> next cycle rs_busy_o = 0, data matches.
- Ports 0 and 1 both write f7 (0x1111…, 0x2222…) -> f7 = 0x2222…, busy cleared.
- Same cycle writeback f9 and alloc f9 (f9 busy) -> alloc_ready_o = 1, f9 holds new data, busy_o[9] = 1.
- Writeback to non-allocated f3 -> f3 updated, err_o = 1 next cycle, stays 1 until arst_ni low.
- Bypass: read f4 while writing 0xDEAD_BEEF to f4 -> with FP_REG_FILE_BYPASS_EN rs_data_o = 0xDEAD_BEEF and rs_busy_o = 0 same cycle; without it old value and stored busy.
